// File: rtl/game_period_ctrl_pkg.sv
// Shared constants for the symbol-counting game round sequencer and its tick generator.
// Holds state encoding, bus widths and the generator period constants.
package game_period_ctrl_pkg;

    localparam int SEC_W   = 7;
    localparam int LVL_W   = 5;
    localparam int SCORE_W = 8;

    // Generator period in core clocks: base period, shortened by one step per level.
    localparam int GEN_BASE_PERIOD = 100_000_000;
    localparam int GEN_LEVEL_STEP  = 5_000_000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRELIM = 3'd1;
    localparam logic [2:0] ST_GAME   = 3'd2;
    localparam logic [2:0] ST_ANSWER = 3'd3;
    localparam logic [2:0] ST_POST   = 3'd4;
    localparam logic [2:0] ST_OVER   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRELIM = ST_PRELIM,
        GAME   = ST_GAME,
        ANSWER = ST_ANSWER,
        POST   = ST_POST,
        OVER   = ST_OVER
    } state_t;

    // Period strobes packed as {post, answer, game, prelim}; all zero outside a period.
    function automatic logic [3:0] periodStrobes(input state_t s);
        logic [3:0] strb;
        strb = 4'b0000;
        case (s)
            PRELIM:  strb = 4'b0001;
            GAME:    strb = 4'b0010;
            ANSWER:  strb = 4'b0100;
            POST:    strb = 4'b1000;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/game_period_ctrl_timer.sv
// Seconds countdown for one game period: load wins over tick, timeout is combinational.
// Latency: timeout is asserted in the same cycle as the tick that finds count==1.
// Backpressure: none; a count of zero holds and ignores ticks.
module period_timer
    import game_period_ctrl_pkg::*;
(
    input  logic             Clk100M,
    input  logic             reset,
    input  logic             load,
    input  logic [SEC_W-1:0] loadVal,
    input  logic             tick,
    output logic [SEC_W-1:0] count,
    output logic             timeout
);

    // The top reacts to timeout on the same edge, so it must not wait for a register.
    assign timeout = tick && (count == SEC_W'(1));

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (tick && (count != '0)) begin
            count <= count - SEC_W'(1);
        end
    end

endmodule

// File: rtl/game_period_ctrl.sv
// Round sequencer: prelim/game/answer/post periods, answer judging, level and score.
// Latency: all outputs registered, strobes rise on the edge the state is entered.
// Backpressure: none; inputs are single-cycle pulses and unused ones are dropped.
module game_period_ctrl
    import game_period_ctrl_pkg::*;
#(
    parameter int PRELIM_SECS = 3,
    parameter int GAME_SECS   = 30,
    parameter int ANSWER_SECS = 10,
    parameter int POST_SECS   = 3,
    parameter int MAX_LEVEL   = 5
) (
    input  logic               Clk100M,
    input  logic               reset,
    input  logic               Clk1Hz,
    input  logic               start,
    input  logic               answerValid,
    input  logic               answerCorrect,
    output logic               prelimPeriod,
    output logic               gamePeriod,
    output logic               answerPeriod,
    output logic               postPeriod,
    output logic [LVL_W-1:0]   level,
    output logic               levelChng,
    output logic [SEC_W-1:0]   secondsLeft,
    output logic [SCORE_W-1:0] score,
    output logic               gameOver,
    output logic               gameWon
);

    state_t           state;
    state_t           nextState;
    logic             roundOk;
    logic             nextRoundOk;
    logic             levelBumped;
    logic             timeout;
    logic             timerLoad;
    logic [SEC_W-1:0] timerLoadVal;
    logic             postDone;
    logic             lastLevel;
    logic             levelInc;
    logic             winNow;

    period_timer u_timer (
        .Clk100M (Clk100M),
        .reset   (reset),
        .load    (timerLoad),
        .loadVal (timerLoadVal),
        .tick    (Clk1Hz),
        .count   (secondsLeft),
        .timeout (timeout)
    );

    assign postDone  = (state == POST) && timeout;
    assign lastLevel = (level >= LVL_W'(MAX_LEVEL));
    assign levelInc  = postDone && roundOk && !lastLevel;
    assign winNow    = postDone && roundOk && lastLevel;

    always_comb begin
        nextState   = state;
        nextRoundOk = roundOk;
        case (state)
            IDLE: begin
                if (start) nextState = PRELIM;
            end
            PRELIM: begin
                if (timeout) nextState = GAME;
            end
            GAME: begin
                if (timeout) begin
                    nextState   = ANSWER;
                    nextRoundOk = 1'b0;
                end
            end
            ANSWER: begin
                // An answer arriving with the final tick still counts.
                if (answerValid) begin
                    nextState   = POST;
                    nextRoundOk = answerCorrect;
                end else if (timeout) begin
                    nextState   = POST;
                    nextRoundOk = 1'b0;
                end
            end
            POST: begin
                if (timeout) begin
                    nextState = (roundOk && !lastLevel) ? PRELIM : OVER;
                end
            end
            default: begin
                nextState = state;
            end
        endcase
    end

    // Every transition reloads the countdown; OVER and IDLE load zero so ticks stall there.
    always_comb begin
        timerLoad    = (nextState != state);
        timerLoadVal = '0;
        case (nextState)
            PRELIM:  timerLoadVal = SEC_W'(PRELIM_SECS);
            GAME:    timerLoadVal = SEC_W'(GAME_SECS);
            ANSWER:  timerLoadVal = SEC_W'(ANSWER_SECS);
            POST:    timerLoadVal = SEC_W'(POST_SECS);
            default: timerLoadVal = '0;
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            state        <= IDLE;
            roundOk      <= 1'b0;
            level        <= LVL_W'(1);
            score        <= '0;
            levelBumped  <= 1'b0;
            levelChng    <= 1'b0;
            prelimPeriod <= 1'b0;
            gamePeriod   <= 1'b0;
            answerPeriod <= 1'b0;
            postPeriod   <= 1'b0;
            gameOver     <= 1'b0;
            gameWon      <= 1'b0;
        end else begin
            state   <= nextState;
            roundOk <= nextRoundOk;
            {postPeriod, answerPeriod, gamePeriod, prelimPeriod} <= periodStrobes(nextState);
            gameOver <= (nextState == OVER);
            gameWon  <= gameWon | winNow;
            if (postDone && roundOk && (score != '1)) begin
                score <= score + SCORE_W'(1);
            end
            if (levelInc) begin
                level <= level + LVL_W'(1);
            end
            // Delay the pulse one extra cycle so the generator samples a settled level.
            levelBumped <= levelInc;
            levelChng   <= levelBumped;
        end
    end

endmodule

// File: doc/game_period_ctrl.md
Name: game_period_ctrl

Overview:
- Round sequencer for the symbol-counting game.
- Consumes the 1 Hz tick from the clock/tick generator and drives the period strobes and level/level-change signals that the generator consumes.
- Sequences each round through prelim, game, answer and post periods, judges the player's answer, advances the level and ends the game.
- Sits between the clock/tick generator, the player input logic and the display.

Parameters:
PRELIM_SECS, 3, length of the preliminary (get-ready) period in seconds, 1..127
GAME_SECS, 30, length of the symbol-generation period in seconds, 1..127
ANSWER_SECS, 10, answer window in seconds, 1..127
POST_SECS, 3, result display period in seconds, 1..127
MAX_LEVEL, 5, final level. Must be ≤5 so the generator's cumulative period reduction (5M × level, summed over levels 2..MAX_LEVEL) stays below 100M.

Ports:
Clk100M  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
Clk1Hz  input  1  one-cycle tick, once per second
start  input  1  one-cycle pulse (debounced button) requesting game start
answerValid  input  1  one-cycle pulse: player submitted an answer
answerCorrect  input  1  qualifies answerValid: 1 = correct count
prelimPeriod  output  1  high throughout PRELIM
gamePeriod  output  1  high throughout GAME
answerPeriod  output  1  high throughout ANSWER
postPeriod  output  1  high throughout POST
level  output  5  current level, 1..MAX_LEVEL
levelChng  output  1  one-cycle pulse after level increments
secondsLeft  output  7  seconds remaining in the current period, for display
score  output  8  correct answers, saturating
gameOver  output  1  high in OVER
gameWon  output  1  high in OVER when all levels were cleared

Behaviour:
- All outputs are registered. Period strobes are one-hot or all zero.
- Reset values:
  - state = IDLE
  - level = 1
  - score = 0
  - secondsLeft = 0
  - all strobes, levelChng, gameOver and gameWon = 0
- Reset applies in any state, mid-round included, and overrides every other input that cycle.
- States: IDLE, PRELIM, GAME, ANSWER, POST, OVER. Encoding constants come from the shared package.
- Period countdown (PRELIM/GAME/ANSWER/POST):
  - Entering a period loads secondsLeft with that period's *_SECS.
  - Each Clk1Hz tick decrements secondsLeft.
  - A tick while secondsLeft==1 is the timeout: transition on that same edge, and secondsLeft loads the next period's value instead of 0.
  - Ticks in IDLE and OVER are ignored.
- IDLE: start -> PRELIM.
- PRELIM: timeout -> GAME.
- GAME: timeout -> ANSWER. roundOk latch cleared on entry to ANSWER.
- ANSWER:
  - First answerValid -> POST; latch roundOk = answerCorrect.
  - Timeout with no answer -> POST with roundOk=0.
  - answerValid and timeout in the same cycle: answerValid wins.
  - answerValid outside ANSWER is ignored.
- POST timeout:
  - roundOk=1: score+1, saturating at 255.
  - roundOk=1 and level<MAX_LEVEL: level+1, -> PRELIM.
  - roundOk=1 and level==MAX_LEVEL: -> OVER, gameWon=1.
  - roundOk=0: -> OVER, gameWon=0.
- OVER:
  - Terminal. Only reset leaves it, because the generator's period only restores on reset.
  - start is ignored. secondsLeft = 0.
- levelChng:
  - Level updates on edge N; levelChng is high for exactly the cycle after edge N+1, i.e. one cycle after level is already stable.
  - Never asserted for the initial level 1.
- start outside IDLE is ignored.
- Strobe timing: strobes change on the same edge as the state. The next-state decode feeds registered strobes, so each strobe rises the cycle the state is entered.

Decomposition:
- Shared package holds:
  - state encoding localparams
  - SEC_W=7, LVL_W=5, SCORE_W=8
  - the generator constants it shares with this block: 100M base period, 5M per-level step
- One natural sub-module: period_timer. Loads a value, decrements on tick, and emits a one-cycle timeout when a tick arrives at count 1.
- The FSM, level and score stay in the top level.

Test Plan:
- Set PRELIM=2, GAME=3, ANSWER=2, POST=1. Reset, then pulse start. Expect prelimPeriod for 2 ticks, gamePeriod for 3, then answerPeriod. Strobes stay one-hot.
- In ANSWER, pulse answerValid with answerCorrect=1. Expect postPeriod next cycle. After 1 tick: level 1->2, levelChng high one cycle after level=2, score=1, prelimPeriod high.
- In ANSWER, send no answer for 2 ticks. Expect POST, then OVER with gameOver=1, gameWon=0, level unchanged; a subsequent start is ignored.
- Issue answerValid (correct) and the timeout tick in the same cycle. Expect roundOk=1 and the level to advance.
- With MAX_LEVEL=2, clear 2 rounds. Expect OVER with gameWon=1, score=2, and exactly one levelChng pulse.
- Assert reset mid-GAME. Next cycle: all strobes 0, level=1, score=0, state IDLE. Ticks then have no effect until start.
